// File: rtl/apb_timer_slave.sv
// APB3 slave with a down-counting timer, sticky expiry flag, registered
// interrupt and four scratch registers. PREADY stretches every access phase
// by WAIT_STATES cycles; unmapped addresses and COUNT writes get PSLVERR.
module apb_timer_slave #(
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  input  logic [3:0]           PSTRB,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 IRQ
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_STATUS = 3'd1;
  localparam logic [2:0] IDX_LOAD   = 3'd2;
  localparam logic [2:0] IDX_COUNT  = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           wcnt_q, wcnt_d;

  logic [1:0]           ctrl_q, ctrl_d;
  logic                 exp_q, exp_d;
  logic [DATAWIDTH-1:0] load_q, load_d;
  logic [DATAWIDTH-1:0] count_q, count_d;
  logic [DATAWIDTH-1:0] scratch_q [4];
  logic [DATAWIDTH-1:0] scratch_d [4];
  logic                 irq_q, irq_d;

  logic                 access;
  logic                 at_limit;
  logic                 done_cycle;
  logic                 first_done;
  logic [2:0]           reg_idx;
  logic                 mapped;
  logic                 bad_access;
  logic                 we;
  logic [DATAWIDTH-1:0] rd_mux;
  logic [1:0]           ctrl_new;
  logic                 start;
  logic                 unused_addr_lsb;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [DATAWIDTH-1:0] merge_bytes(
    input logic [DATAWIDTH-1:0] old_val,
    input logic [DATAWIDTH-1:0] new_val,
    input logic [3:0]           strb
  );
    logic [DATAWIDTH-1:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  assign unused_addr_lsb = ^PADDR[1:0];

  assign access     = PSEL & PENABLE;
  assign at_limit   = (wcnt_q == WS);
  assign done_cycle = access & at_limit;
  // A stretched DONE (PENABLE held) must not commit the write twice.
  assign first_done = done_cycle & (state_q != S_DONE);

  assign reg_idx    = PADDR[4:2];
  assign mapped     = (PADDR[ADDRWIDTH-1:5] == '0);
  assign bad_access = !mapped | (PWRITE & (reg_idx == IDX_COUNT));
  assign we         = first_done & PWRITE & !bad_access;

  // Reset forces PREADY high at once so an abandoned transfer cannot stall the bus.
  assign PREADY  = HRESET | !access | at_limit;
  assign PSLVERR = !HRESET & done_cycle & bad_access;
  assign PRDATA  = (!HRESET && done_cycle && mapped) ? rd_mux : '0;
  assign IRQ     = irq_q;

  // Access FSM next state and wait counter: clear when idle, count while waiting.
  always_comb begin
    state_d = S_IDLE;
    wcnt_d  = '0;
    if (access) begin
      if (at_limit) begin
        state_d = S_DONE;
        wcnt_d  = wcnt_q;
      end else begin
        state_d = S_WAIT;
        wcnt_d  = wcnt_q + 3'd1;
      end
    end
  end

  // Access FSM state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Read data mux over the register map.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      IDX_CTRL:   rd_mux = {{(DATAWIDTH-2){1'b0}}, ctrl_q};
      IDX_STATUS: rd_mux = {{(DATAWIDTH-1){1'b0}}, exp_q};
      IDX_LOAD:   rd_mux = load_q;
      IDX_COUNT:  rd_mux = count_q;
      default:    rd_mux = scratch_q[reg_idx[1:0]];
    endcase
  end

  // Register writes, timer counting and expiry; a hardware EXP set overrides a same-cycle W1C.
  always_comb begin
    ctrl_d    = ctrl_q;
    exp_d     = exp_q;
    load_d    = load_q;
    count_d   = count_q;
    scratch_d = scratch_q;
    ctrl_new  = {PSTRB[0] ? PWDATA[1] : ctrl_q[1], PSTRB[0] ? PWDATA[0] : ctrl_q[0]};
    start     = 1'b0;

    if (we) begin
      case (reg_idx)
        IDX_CTRL: begin
          ctrl_d = ctrl_new;
          start  = ctrl_new[0] & !ctrl_q[0];
        end
        IDX_STATUS: begin
          if (PSTRB[0] && PWDATA[0]) exp_d = 1'b0;
        end
        IDX_LOAD:  load_d = merge_bytes(load_q, PWDATA, PSTRB);
        IDX_COUNT: ;
        default:   scratch_d[reg_idx[1:0]] = merge_bytes(scratch_q[reg_idx[1:0]], PWDATA, PSTRB);
      endcase
    end

    // EN is sampled from the current register, so disabling in the expiry
    // cycle still lets this reload and flag happen.
    if (start) begin
      count_d = load_q;
    end else if (ctrl_q[0]) begin
      if (count_q == '0) begin
        count_d = load_q;
        exp_d   = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end

    irq_d = exp_q & ctrl_q[1];
  end

  // Register state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_q  <= '0;
      exp_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < 4; i++) scratch_q[i] <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      exp_q     <= exp_d;
      load_q    <= load_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
      scratch_q <= scratch_d;
    end
  end

endmodule
